// File: rtl/child_seq_pkg.sv
// Shared types and helpers for the child start-up sequencer.
package child_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    FINISH,
    ERROR
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/child_seq_timer.sv
// Watchdog counter: cleared outside WAIT, counts while enabled, holds at TIMEOUT-1.
module child_seq_timer #(
  parameter int TMR_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] count_q;

  assign expire = (count_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable && !expire) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/child_seq_ctrl.sv
// Start-up sequencer: launches each child in index order and waits for its done.
//
//  state  | meaning
//  IDLE   | waiting for start_i
//  LAUNCH | one-cycle start pulse to child[idx]
//  WAIT   | watching child_done_i[idx] under the watchdog
//  FINISH | all children done, done_o pulse
//  ERROR  | child[err_idx] timed out, error_o held until start_i/abort_i
module child_seq_ctrl
  import child_seq_pkg::*;
#(
  parameter int NUM_CHILD = 5,
  parameter int TIMEOUT   = 200,
  parameter int TMR_W     = 8,
  localparam int IDX_W    = idx_w(NUM_CHILD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic [NUM_CHILD-1:0] child_start_o,
  input  logic [NUM_CHILD-1:0] child_done_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [IDX_W-1:0]     err_idx_o,
  output logic [IDX_W-1:0]     cur_idx_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHILD - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;
  logic             err_q, err_d;
  logic             expire;
  logic             done_sel;
  logic             tmr_clear;
  logic             tmr_enable;

  assign tmr_enable = (state_q == WAIT);
  assign tmr_clear  = (state_q != WAIT);

  child_seq_timer #(
    .TMR_W   (TMR_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expire (expire)
  );

  assign done_sel = child_done_i[idx_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_d   = LAUNCH;
          idx_d     = '0;
          err_d     = 1'b0;
          err_idx_d = '0;
        end
      end
      LAUNCH: begin
        if (abort_i) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // abort beats done, and done beats a same-cycle timeout
        if (abort_i) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (done_sel) begin
          if (idx_q == LAST_IDX) begin
            state_d = FINISH;
          end else begin
            state_d = LAUNCH;
            idx_d   = idx_q + 1'b1;
          end
        end else if (expire) begin
          state_d   = ERROR;
          err_d     = 1'b1;
          err_idx_d = idx_q;
        end
      end
      FINISH: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      ERROR: begin
        if (abort_i) begin
          state_d   = IDLE;
          idx_d     = '0;
          err_d     = 1'b0;
          err_idx_d = '0;
        end else if (start_i) begin
          state_d   = LAUNCH;
          idx_d     = '0;
          err_d     = 1'b0;
          err_idx_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign child_start_o = (state_q == LAUNCH) ? (NUM_CHILD'(1) << idx_q) : '0;
  assign busy_o        = (state_q == LAUNCH) || (state_q == WAIT) || (state_q == FINISH);
  // an abort landing on the FINISH cycle suppresses the completion pulse
  assign done_o        = (state_q == FINISH) && !abort_i;
  assign error_o       = err_q;
  assign err_idx_o     = err_idx_q;
  assign cur_idx_o     = idx_q;

endmodule
